// File: rtl/cdb_rr_arbiter.sv
// Round-robin Common Data Bus arbiter: grants up to NUM_CDB of NUM_FU finished results per cycle
// and broadcasts them on registered lanes. Optional squash input enabled by CDB_FLUSH_EN.
module cdb_rr_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_FU     = 3,
    parameter int unsigned NUM_CDB    = 1,
    localparam int unsigned ID_W      = $clog2(NUM_FU)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_FU-1:0]             fu_valid,
    input  logic [NUM_FU*DATA_WIDTH-1:0]  fu_result,
    output logic [NUM_FU-1:0]             fu_ready,
`ifdef CDB_FLUSH_EN
    input  logic                          flush,
`endif
    output logic [NUM_CDB-1:0]            cdb_valid,
    output logic [NUM_CDB*ID_W-1:0]       cdb_rs_id,
    output logic [NUM_CDB*DATA_WIDTH-1:0] cdb_result,
    output logic [ID_W-1:0]               rr_ptr
);

    logic                                flush_int;
    logic [NUM_FU-1:0][DATA_WIDTH-1:0]   fu_res;
    logic [NUM_FU-1:0]                   grant;
    logic [NUM_CDB-1:0]                  lane_valid;
    logic [NUM_CDB-1:0][ID_W-1:0]        lane_id;
    logic [NUM_CDB-1:0][DATA_WIDTH-1:0]  lane_data;
    logic [ID_W-1:0]                     ptr_nxt;
    logic [ID_W:0]                       sum;
    logic [ID_W-1:0]                     idx;
    int unsigned                         cnt;

    logic [NUM_CDB-1:0]                  valid_q;
    logic [NUM_CDB-1:0][ID_W-1:0]        id_q;
    logic [NUM_CDB-1:0][DATA_WIDTH-1:0]  res_q;
    logic [ID_W-1:0]                     rr_ptr_q;

`ifdef CDB_FLUSH_EN
    assign flush_int = flush;
`else
    assign flush_int = 1'b0;
`endif

    assign fu_res = fu_result;

    // Walk FUs in priority order from rr_ptr; the k-th requester found lands on lane k.
    always_comb begin
        grant      = '0;
        lane_valid = '0;
        lane_id    = '0;
        lane_data  = '0;
        ptr_nxt    = rr_ptr_q;
        sum        = '0;
        idx        = '0;
        cnt        = 0;
        for (int unsigned j = 0; j < NUM_FU; j++) begin
            sum = {1'b0, rr_ptr_q} + (ID_W+1)'(j);
            if (sum >= (ID_W+1)'(NUM_FU)) begin
                sum = sum - (ID_W+1)'(NUM_FU);
            end
            idx = sum[ID_W-1:0];
            if (fu_valid[idx] && (cnt < NUM_CDB) && !flush_int) begin
                grant[idx] = 1'b1;
                for (int unsigned k = 0; k < NUM_CDB; k++) begin
                    if (k == cnt) begin
                        lane_valid[k] = 1'b1;
                        lane_id[k]    = idx;
                        lane_data[k]  = fu_res[idx];
                    end
                end
                // Explicit wrap so non-power-of-two NUM_FU returns to 0.
                ptr_nxt = (idx == ID_W'(NUM_FU - 1)) ? '0 : idx + 1'b1;
                cnt     = cnt + 1;
            end
        end
    end

    assign fu_ready = grant & {NUM_FU{rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            id_q     <= '0;
            res_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= lane_valid;
            rr_ptr_q <= ptr_nxt;
            // Idle lanes keep stale id/data; consumers only look at cdb_valid.
            for (int unsigned k = 0; k < NUM_CDB; k++) begin
                if (lane_valid[k]) begin
                    id_q[k]  <= lane_id[k];
                    res_q[k] <= lane_data[k];
                end
            end
        end
    end

    assign cdb_valid  = valid_q;
    assign cdb_rs_id  = id_q;
    assign cdb_result = res_q;
    assign rr_ptr     = rr_ptr_q;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Bench for cdb_rr_arbiter: a 3-FU/1-lane and a 4-FU/2-lane instance checked against a
// priority-list reference model with directed and random traffic.
module tb_cdb_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic fl;

    logic [2:0]   fu_valid_a;
    logic [191:0] fu_result_a;
    logic [2:0]   fu_ready_a;
    logic [0:0]   cdb_valid_a;
    logic [1:0]   cdb_rs_id_a;
    logic [63:0]  cdb_result_a;
    logic [1:0]   rr_ptr_a;

    logic [3:0]   fu_valid_b;
    logic [255:0] fu_result_b;
    logic [3:0]   fu_ready_b;
    logic [1:0]   cdb_valid_b;
    logic [3:0]   cdb_rs_id_b;
    logic [127:0] cdb_result_b;
    logic [1:0]   rr_ptr_b;

    logic [63:0] res_a [3];
    logic [63:0] res_b [4];
    logic [3:0]  va;
    logic [3:0]  vb;

    int exp_ptr_a;
    logic exp_cv_a;
    int exp_id_a;
    logic [63:0] exp_res_a;
    int exp_ptr_b;
    logic exp_cv_b [2];
    int exp_id_b [2];
    logic [63:0] exp_res_b [2];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    cdb_rr_arbiter #(.DATA_WIDTH(64), .NUM_FU(3), .NUM_CDB(1)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .fu_valid   (fu_valid_a),
        .fu_result  (fu_result_a),
        .fu_ready   (fu_ready_a),
`ifdef CDB_FLUSH_EN
        .flush      (fl),
`endif
        .cdb_valid  (cdb_valid_a),
        .cdb_rs_id  (cdb_rs_id_a),
        .cdb_result (cdb_result_a),
        .rr_ptr     (rr_ptr_a)
    );

    cdb_rr_arbiter #(.DATA_WIDTH(64), .NUM_FU(4), .NUM_CDB(2)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .fu_valid   (fu_valid_b),
        .fu_result  (fu_result_b),
        .fu_ready   (fu_ready_b),
`ifdef CDB_FLUSH_EN
        .flush      (fl),
`endif
        .cdb_valid  (cdb_valid_b),
        .cdb_rs_id  (cdb_rs_id_b),
        .cdb_result (cdb_result_b),
        .rr_ptr     (rr_ptr_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Priority list ptr, ptr+1, ... mod n; first c valid entries win.
    function automatic void model(input int n, input int c, input int ptr, input logic [3:0] v,
                                  input logic f, output logic [3:0] rdy, output int id0,
                                  output int id1, output int ngr, output int nptr);
        rdy  = '0;
        id0  = 0;
        id1  = 0;
        ngr  = 0;
        nptr = ptr;
        if (!f) begin
            for (int j = 0; j < n; j++) begin
                int fu;
                fu = (ptr + j) % n;
                if (v[fu] && ngr < c) begin
                    rdy[fu] = 1'b1;
                    if (ngr == 0) id0 = fu;
                    else id1 = fu;
                    ngr++;
                    nptr = (fu + 1) % n;
                end
            end
        end
    endfunction

    task automatic reset_model();
        exp_ptr_a = 0;
        exp_cv_a  = 1'b0;
        exp_ptr_b = 0;
        exp_cv_b  = '{1'b0, 1'b0};
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rdy_a"}, 64'(fu_ready_a), 64'd0);
        check({tag, "_rdy_b"}, 64'(fu_ready_b), 64'd0);
        check({tag, "_cv_a"}, 64'(cdb_valid_a), 64'd0);
        check({tag, "_cv_b"}, 64'(cdb_valid_b), 64'd0);
        check({tag, "_ptr_a"}, 64'(rr_ptr_a), 64'd0);
        check({tag, "_ptr_b"}, 64'(rr_ptr_b), 64'd0);
        check({tag, "_id_b"}, 64'(cdb_rs_id_b), 64'd0);
        check({tag, "_res_a"}, cdb_result_a, 64'd0);
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic cycle();
        logic [3:0] rdy_a, rdy_b;
        int a0, a1, na, pa, b0, b1, nb, pb;
        fu_valid_a = va[2:0];
        fu_valid_b = vb;
        for (int i = 0; i < 3; i++) fu_result_a[i*64 +: 64] = res_a[i];
        for (int i = 0; i < 4; i++) fu_result_b[i*64 +: 64] = res_b[i];
        #1;
        model(3, 1, exp_ptr_a, va, fl, rdy_a, a0, a1, na, pa);
        model(4, 2, exp_ptr_b, vb, fl, rdy_b, b0, b1, nb, pb);
        check("rdy_a", 64'(fu_ready_a), 64'(rdy_a[2:0]));
        check("cv_a", 64'(cdb_valid_a), 64'(exp_cv_a));
        check("ptr_a", 64'(rr_ptr_a), 64'(exp_ptr_a));
        if (exp_cv_a) begin
            check("id_a", 64'(cdb_rs_id_a), 64'(exp_id_a));
            check("res_a", cdb_result_a, exp_res_a);
        end
        check("rdy_b", 64'(fu_ready_b), 64'(rdy_b));
        check("cv_b", 64'(cdb_valid_b), 64'({exp_cv_b[1], exp_cv_b[0]}));
        check("ptr_b", 64'(rr_ptr_b), 64'(exp_ptr_b));
        for (int k = 0; k < 2; k++) begin
            if (exp_cv_b[k]) begin
                check("id_b", 64'(cdb_rs_id_b[k*2 +: 2]), 64'(exp_id_b[k]));
                check("res_b", cdb_result_b[k*64 +: 64], exp_res_b[k]);
            end
        end
        @(posedge clk);
        exp_cv_a = (na > 0);
        if (na > 0) begin
            exp_id_a  = a0;
            exp_res_a = res_a[a0];
        end
        exp_ptr_a = pa;
        exp_cv_b[0] = (nb > 0);
        exp_cv_b[1] = (nb > 1);
        if (nb > 0) begin
            exp_id_b[0]  = b0;
            exp_res_b[0] = res_b[b0];
        end
        if (nb > 1) begin
            exp_id_b[1]  = b1;
            exp_res_b[1] = res_b[b1];
        end
        exp_ptr_b = pb;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] vb_seq [6];
        vb_seq = '{4'b0111, 4'b0100, 4'b1011, 4'b0010, 4'b0000, 4'b0000};
        rst_n = 1'b0;
        fl    = 1'b0;
        va    = 4'b0111;
        vb    = 4'b1111;
        res_a = '{64'h1111, 64'hDEAD, 64'h2222};
        res_b = '{64'hB0, 64'hB1, 64'hB2, 64'hB3};
        fu_valid_a = 3'b111;
        fu_valid_b = 4'b1111;
        fu_result_a = '0;
        fu_result_b = '0;
        reset_model();
        #12;
        check_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single-lane rotation on A alongside the dual-lane scenario on B.
        for (int i = 0; i < 6; i++) begin
            vb = vb_seq[i];
            cycle();
            check("rot_id_a", 64'(cdb_rs_id_a), 64'(i % 3));
            if (i % 3 == 1) check("rot_dead_a", cdb_result_a, 64'hDEAD);
            if (i == 2) begin
                check("dual_l0_b", 64'(cdb_rs_id_b[1:0]), 64'd3);
                check("dual_l1_b", 64'(cdb_rs_id_b[3:2]), 64'd0);
                check("dual_ptr_b", 64'(rr_ptr_b), 64'd1);
            end
            if (i == 3) begin
                check("dual_next_b", 64'(cdb_rs_id_b[1:0]), 64'd1);
                check("dual_cv_b", 64'(cdb_valid_b), 64'b01);
            end
        end

        // Sparse request: pointer at 1, only FU0 asks, then nobody.
        va = 4'b0111;
        cycle();
        va = 4'b0001;
        cycle();
        check("sparse_id_a", 64'(cdb_rs_id_a), 64'd0);
        check("sparse_ptr_a", 64'(rr_ptr_a), 64'd1);
        va = 4'b0000;
        cycle();
        check("idle_cv_a", 64'(cdb_valid_a), 64'd0);
        check("idle_ptr_a", 64'(rr_ptr_a), 64'd1);

`ifdef CDB_FLUSH_EN
        va = 4'b0111;
        vb = 4'b1111;
        fl = 1'b1;
        cycle();
        fl = 1'b0;
        check("flush_cv_a", 64'(cdb_valid_a), 64'd0);
        check("flush_ptr_a", 64'(rr_ptr_a), 64'd1);
        cycle();
`endif

        // Random traffic with a mid-burst asynchronous reset pulse.
        for (int i = 0; i < 200; i++) begin
            va = 4'($urandom);
            vb = 4'($urandom);
            for (int f = 0; f < 3; f++) res_a[f] = {$urandom, $urandom};
            for (int f = 0; f < 4; f++) res_b[f] = {$urandom, $urandom};
            cycle();
            if (i == 100) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_reset("midrst");
                reset_model();
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
